// File: rtl/gps_iq_sched.sv
// Readout scheduler for the GPS correlator channels: round-robin arbitration of the single
// serial IQ path, per-word deserialisation and valid/ready delivery to the CPU side.
module gps_iq_sched #(
    parameter int unsigned NCHAN      = 12,
    parameter int unsigned INTEG_BITS = 18,
    parameter int unsigned CHW        = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NCHAN-1:0]      chan_en,
    input  logic [NCHAN-1:0]      ms0,
    input  logic [NCHAN-1:0]      sout,
    output logic [NCHAN-1:0]      shift,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [INTEG_BITS-1:0] out_data,
    output logic [CHW-1:0]        out_chan,
    output logic [2:0]            out_idx,
    output logic                  out_last,
    output logic [NCHAN-1:0]      ovr,
    input  logic [NCHAN-1:0]      ovr_clr,
    output logic                  busy
);

    localparam int unsigned BCW = $clog2(INTEG_BITS);
    localparam logic [BCW-1:0] LastBit = BCW'(INTEG_BITS - 1);
    localparam logic [NCHAN-1:0] ChanOne = NCHAN'(1);
    localparam logic [2:0] LastWord = 3'd5;

    typedef enum logic [1:0] {StIdle, StShift, StPresent} state_e;

    state_e                state_q;
    logic [CHW-1:0]        cur_q;
    logic [CHW-1:0]        rr_q;
    logic [BCW-1:0]        bitcnt_q;
    logic [2:0]            wordcnt_q;
    logic [INTEG_BITS-2:0] word_q;
    logic [NCHAN-1:0]      pend_q;
    logic                  aborted_q;

    logic [NCHAN-1:0]      eligible;
    logic [NCHAN-1:0]      grant_mask;
    logic [NCHAN-1:0]      abort_mask;
    logic [NCHAN-1:0]      pend_d;
    logic [NCHAN-1:0]      ovr_d;
    logic                  found;
    logic [CHW-1:0]        sel;
    logic [CHW:0]          cand;
    logic                  abort;
    logic [INTEG_BITS-1:0] shifted;

    // A channel pulsing ms0 this cycle is about to reload, so it must not be granted yet.
    assign eligible = pend_q & chan_en & ~ms0;

    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int unsigned k = 1; k <= NCHAN; k++) begin
            cand = {1'b0, rr_q} + (CHW + 1)'(k);
            if (cand >= (CHW + 1)'(NCHAN)) begin
                cand = cand - (CHW + 1)'(NCHAN);
            end
            if (!found && eligible[cand[CHW-1:0]]) begin
                found = 1'b1;
                sel   = cand[CHW-1:0];
            end
        end
    end

    assign abort      = (state_q != StIdle) && ms0[cur_q];
    assign abort_mask = abort ? (ChanOne << cur_q) : '0;
    assign grant_mask = (state_q == StIdle && found) ? (ChanOne << sel) : '0;

    // New epochs win over the grant clear; an abort re-arms its channel the same way.
    assign pend_d = ((pend_q & ~grant_mask) | ms0) & chan_en;
    assign ovr_d  = (ovr & ~ovr_clr) | (ms0 & pend_q) | abort_mask;

    assign shifted = {word_q, sout[cur_q]};
    assign shift   = (state_q == StShift) ? (ChanOne << cur_q) : '0;
    assign busy    = (state_q != StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cur_q     <= '0;
            rr_q      <= CHW'(NCHAN - 1);
            bitcnt_q  <= '0;
            wordcnt_q <= '0;
            word_q    <= '0;
            pend_q    <= '0;
            aborted_q <= 1'b0;
            ovr       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            ovr    <= ovr_d;
            unique case (state_q)
                StIdle: begin
                    if (found) begin
                        cur_q     <= sel;
                        rr_q      <= sel;
                        bitcnt_q  <= '0;
                        wordcnt_q <= '0;
                        aborted_q <= 1'b0;
                        state_q   <= StShift;
                    end
                end
                StShift: begin
                    if (abort) begin
                        state_q <= StIdle;
                    end else begin
                        word_q   <= shifted[INTEG_BITS-2:0];
                        bitcnt_q <= bitcnt_q + 1'b1;
                        if (bitcnt_q == LastBit) begin
                            out_valid <= 1'b1;
                            out_data  <= shifted;
                            out_chan  <= cur_q;
                            out_idx   <= wordcnt_q;
                            out_last  <= (wordcnt_q == LastWord);
                            state_q   <= StPresent;
                        end
                    end
                end
                StPresent: begin
                    if (abort) begin
                        aborted_q <= 1'b1;
                    end
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (wordcnt_q == LastWord || abort || aborted_q) begin
                            state_q <= StIdle;
                        end else begin
                            wordcnt_q <= wordcnt_q + 1'b1;
                            bitcnt_q  <= '0;
                            state_q   <= StShift;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
